mem_stage: RTL
==============

# mem_stage

Memory-access stage directly downstream of the execute stage. Takes the registered EX/MEM instruction (ALU result as address or pass-through value, rs2 value as store data, funct3 as size/sign) and runs a req/ack handshake to data memory. It formats load data with byte/half extraction and sign or zero extension. It stalls upstream while an access is outstanding and flags misaligned, illegal or timed-out accesses.

## Interface
- TIMEOUT, 16: maximum cycles dmem_req stays high without dmem_ack before the access is aborted (≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_mem_valid_inst  in  1  instruction in EX/MEM register is valid.
- ex_mem_rd_mem  in  1  instruction is a load.
- ex_mem_wr_mem  in  1  instruction is a store.
- ex_mem_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- ex_mem_alu_result  in  32  byte address for memory ops, result otherwise.
- ex_mem_regb  in  32  store data.
- mem_stall  out  1  upstream must hold EX/MEM contents this cycle.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- dmem_ack  in  1  request completed this cycle.
- mem_result_out  out  32  registered writeback value.
- mem_result_valid  out  1  one-cycle pulse: mem_result_out updated.
- mem_fault  out  1  one-cycle pulse with mem_result_valid: access faulted.

## Operation
- States: IDLE, REQ. Wait counter cnt, width $clog2(TIMEOUT+1).
- IDLE, valid non-memory instr: next edge mem_result_out <= ex_mem_alu_result, valid pulse, no stall.
- IDLE, ex_mem_valid_inst=0: no pulse, outputs hold.
- IDLE, memory op, legal and aligned: mem_stall=1 (combinational). Next edge -> REQ, latch dmem_addr/be/wdata/we, dmem_req<=1, cnt<=0.
- Illegal: rd_mem&wr_mem both 1; load funct3 011/110/111; store funct3[2]=1. Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0. Either: no request, no stall; next edge mem_result_out<=0, valid and fault pulse.
- Byte enables: B = 4'b0001<<addr[1:0]; H = addr[1]?4'b1100:4'b0011; W = 4'b1111 (loads and stores).
- Store data: SB {4{regb[7:0]}}, SH {2{regb[15:0]}}, SW regb.
- REQ: dmem_req, addr, be, wdata, we held stable; EX/MEM inputs ignored. mem_stall = !dmem_ack.
- REQ with dmem_ack=1: next edge -> IDLE, dmem_req<=0, valid pulse. Load: mem_result_out <= extended lane (rdata>>8*addr[1:0], B/H sign-extended, BU/HU zero-extended). Store: mem_result_out <= byte address.
- REQ, no ack: cnt increments. When cnt==TIMEOUT-1 and no ack: -> IDLE, dmem_req<=0, mem_result_out<=32'hbaadbeef, valid and fault pulse; mem_stall=0 that cycle.
- Ack in the same cycle as the timeout count: success takes priority.
- Reset (any state): state IDLE, cnt 0, dmem_req/we/be/addr/wdata 0, mem_result_out 0, valid 0, fault 0. In-flight request dropped immediately, no pulse.

## Timing
- Non-memory and faulting ops: result 1 cycle after presentation, zero stall.
- Memory op presented cycle 0: stall cycle 0; dmem_req high from cycle 1; ack in cycle k≥1 -> stall low in cycle k, result and valid in cycle k+1. Minimum load-to-result latency 2 cycles.
- Upstream advances on the edge that ends an ack cycle; the next instruction is evaluated in IDLE the following cycle. No back-to-back re-issue of the same instruction.
- dmem_req high for at most TIMEOUT consecutive cycles.
- mem_result_valid and mem_fault never high two consecutive cycles for one instruction.

## Test plan
- Reset mid-REQ: dmem_req=1, pull rst low -> dmem_req, mem_result_valid, mem_stall-related state 0 immediately; after release, IDLE with no pulse.
- ALU pass-through: valid, alu_result=0x12345678, no mem flags -> next cycle mem_result_out=0x12345678, valid=1, mem_stall never 1.
- LB from 0x1003, rdata=0x80FFFFFF, ack on first REQ cycle -> dmem_addr=0x1000, be=4'b1000, we=0; result 0xFFFFFF80 two cycles after presentation. Same with LBU -> 0x00000080.
- SH to 0x2002, regb=0xAAAABEEF, ack after 3 cycles -> be=4'b1100, wdata=0xBEEFBEEF, we=1; stall for 4 cycles; valid with result 0x00002002.
- LW at 0x3001 -> no dmem_req; next cycle valid=1, fault=1, result 0. Both rd_mem and wr_mem set -> same response.
- TIMEOUT=16, LW to 0x4000, ack never -> dmem_req high exactly 16 cycles; then result 0xbaadbeef, fault=1, stall low. Repeat with ack on the 16th cycle -> normal result, fault=0.

Source files
------------

// File: rtl/mem_stage_if.sv
// EX/MEM instruction fields, data-memory req/ack channel and writeback result of the memory stage.
// slave is the stage's view; master is the upstream/memory/testbench view.
interface mem_stage_if;
  logic        ex_mem_valid_inst;
  logic        ex_mem_rd_mem;
  logic        ex_mem_wr_mem;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_regb;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] mem_result_out;
  logic        mem_result_valid;
  logic        mem_fault;

  modport slave (
    input  ex_mem_valid_inst, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_funct3,
    input  ex_mem_alu_result, ex_mem_regb, dmem_rdata, dmem_ack,
    output mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output mem_result_out, mem_result_valid, mem_fault
  );

  modport master (
    output ex_mem_valid_inst, ex_mem_rd_mem, ex_mem_wr_mem, ex_mem_funct3,
    output ex_mem_alu_result, ex_mem_regb, dmem_rdata, dmem_ack,
    input  mem_stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  mem_result_out, mem_result_valid, mem_fault
  );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: load/store via dmem req/ack, lane extract + extension; result 1 cycle after ack (or presentation for
// non-memory/faulting ops). Stalls upstream while a request is outstanding; aborts after TIMEOUT unacked cycles.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mem_stage_if.slave  io_bus
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req;
  logic               r_we;
  logic [3:0]         r_be;
  logic [31:0]        r_baddr;
  logic [31:0]        r_wdata;
  logic [2:0]         r_f3;
  logic [31:0]        r_result;
  logic               r_valid;
  logic               r_fault;

  logic               w_mem_op;
  logic               w_illegal;
  logic               w_misalign;
  logic               w_timeout;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata;
  logic [31:0]        w_lane;
  logic [31:0]        w_load_val;

  always_comb begin
    w_mem_op   = io_bus.ex_mem_valid_inst & (io_bus.ex_mem_rd_mem | io_bus.ex_mem_wr_mem);
    w_illegal  = (io_bus.ex_mem_rd_mem & io_bus.ex_mem_wr_mem)
               | (io_bus.ex_mem_rd_mem & ((io_bus.ex_mem_funct3 == 3'b011) ||
                                          (io_bus.ex_mem_funct3[2:1] == 2'b11)))
               | (io_bus.ex_mem_wr_mem & io_bus.ex_mem_funct3[2]);
    w_misalign = ((io_bus.ex_mem_funct3[1:0] == 2'b01) && io_bus.ex_mem_alu_result[0])
               || ((io_bus.ex_mem_funct3[1:0] == 2'b10) && (io_bus.ex_mem_alu_result[1:0] != 2'b00));
    w_timeout  = (r_cnt == CNT_W'(TIMEOUT - 1));

    w_be    = 4'b1111;
    w_wdata = io_bus.ex_mem_regb;
    case (io_bus.ex_mem_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << io_bus.ex_mem_alu_result[1:0];
        w_wdata = {4{io_bus.ex_mem_regb[7:0]}};
      end
      2'b01: begin
        w_be    = io_bus.ex_mem_alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{io_bus.ex_mem_regb[15:0]}};
      end
      default: ;
    endcase

    // Shift the addressed lane down to bit 0 before size/sign formatting.
    w_lane = io_bus.dmem_rdata >> {r_baddr[1:0], 3'b000};
    case (r_f3)
      3'b000:  w_load_val = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_val = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_val = {24'h0, w_lane[7:0]};
      3'b101:  w_load_val = {16'h0, w_lane[15:0]};
      default: w_load_val = w_lane;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_be     <= 4'b0000;
      r_baddr  <= 32'h0;
      r_wdata  <= 32'h0;
      r_f3     <= 3'b000;
      r_result <= 32'h0;
      r_valid  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (io_bus.ex_mem_valid_inst) begin
            if (!w_mem_op) begin
              r_result <= io_bus.ex_mem_alu_result;
              r_valid  <= 1'b1;
            end else if (w_illegal || w_misalign) begin
              r_result <= 32'h0;
              r_valid  <= 1'b1;
              r_fault  <= 1'b1;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_we    <= io_bus.ex_mem_wr_mem;
              r_be    <= w_be;
              r_baddr <= io_bus.ex_mem_alu_result;
              r_wdata <= w_wdata;
              r_f3    <= io_bus.ex_mem_funct3;
              r_cnt   <= '0;
            end
          end
        end
        REQ: begin
          // An ack in the timeout cycle still completes normally.
          if (io_bus.dmem_ack) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_result <= r_we ? r_baddr : w_load_val;
            r_valid  <= 1'b1;
          end else if (w_timeout) begin
            r_state  <= IDLE;
            r_req    <= 1'b0;
            r_result <= 32'hbaadbeef;
            r_valid  <= 1'b1;
            r_fault  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.mem_stall        = (r_state == IDLE) ? (w_mem_op & ~w_illegal & ~w_misalign)
                                                     : (~io_bus.dmem_ack & ~w_timeout);
  assign io_bus.dmem_req         = r_req;
  assign io_bus.dmem_we          = r_we;
  assign io_bus.dmem_addr        = {r_baddr[31:2], 2'b00};
  assign io_bus.dmem_be          = r_be;
  assign io_bus.dmem_wdata       = r_wdata;
  assign io_bus.mem_result_out   = r_result;
  assign io_bus.mem_result_valid = r_valid;
  assign io_bus.mem_fault        = r_fault;
endmodule
